arinc429_txd: RTL
=================

# arinc429_txd

ARINC 429 word transmitter, the send-side counterpart of the team's `AR_RXD_2` receiver. It accepts an 8-bit label (`sr_adr`) and a 23-bit data field (`sr_dat`) on a start strobe. It appends odd parity and serialises the 32-bit word MSB-first as bipolar return-to-zero pulses on the `out1`/`out0` line pair, at one of four selectable bit rates. It sits between the host write logic and the line driver, and loops back directly onto the receiver's `in1`/`in0` inputs for self-test.

## Interface
- `Fclk`, default 50000000: system clock frequency in Hz.
- `V1Mb`, default 1000000: bit rate in b/s selected by `vel=3`.
- `V100kb`, default 100000: bit rate in b/s selected by `vel=2`.
- `V50kb`, default 50000: bit rate in b/s selected by `vel=1`.
- `V12_5kb`, default 12500: bit rate in b/s selected by `vel=0`.
- `GAP_BITS`, default 4: null bit-times inserted after every word.
- `clk`, in, 1: single system clock; all logic on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `st`, in, 1: start strobe; sampled only while `busy=0`.
- `vel`, in, 2: rate select; latched when `st` is accepted.
- `sr_adr`, in, 8: label; latched when `st` is accepted.
- `sr_dat`, in, 23: data field; latched when `st` is accepted.
- `out1`, out, 1: line pulse for a `1` bit.
- `out0`, out, 1: line pulse for a `0` bit.
- `busy`, out, 1: high from the first cycle after `st` is accepted until the word and gap are complete.
- `done`, out, 1: one-cycle pulse at word completion.

## Operation
- Half-bit length: Nt = Fclk/(2·V) for the latched `vel`. Defaults give 25, 250, 500 and 2000 clocks. The half-bit counter is 11 bits wide.
- Word assembly at accept:
  - w[31:24] = `sr_adr`
  - w[23-i] = `sr_dat[i]` for i = 0..22
  - w[0] = ~^w[31:1], so the total number of ones in w is odd.
- States:
  - IDLE: outputs null. If `st=1`, latch w and Nt, set bit index to 31 and go to PULSE.
  - PULSE: drive `out1` if the current bit is 1, else `out0`, for Nt cycles, then go to NULL.
  - NULL: both outputs low for Nt cycles. If bit index is 0, go to GAP; otherwise decrement the index and go to PULSE.
  - GAP: both outputs low for GAP_BITS·2·Nt cycles, then return to IDLE and pulse `done`.
- Outputs are registered. `out1` and `out0` are never high together. Outside PULSE both are 0.
- `st` while `busy=1` is ignored and not queued. Changes to `vel`, `sr_adr` or `sr_dat` while busy have no effect on the word in flight.
- Reset values: `out1=0`, `out0=0`, `busy=0`, `done=0`, state IDLE, all counters 0.
- Asserting `rst_n=0` mid-word nulls the line immediately, with no clock required, and abandons the word. The first accept after release starts a fresh word.

## Timing
- Edge E0 samples `st=1` in IDLE. After E0, `busy=1` and the first pulse (bit 31) is on the line.
- Each bit lasts 2·Nt cycles: Nt of pulse, then Nt of null.
- `busy` stays high for exactly (32+GAP_BITS)·2·Nt cycles; with defaults at `vel=3` this is 1800 cycles.
- In the cycle after the last busy cycle, `busy=0` and `done=1`.
- `st=1` in that same cycle is accepted, giving back-to-back words with exactly the GAP_BITS null gap.
- `st` held high continuously produces consecutive words, each separated by the gap.
- Pulse edges fall exactly on half-bit counter boundaries, with zero cycles of skew between `out1` and `out0` transitions.

## Test plan
- **Reset and idle:** assert `rst_n=0` with `st=0`, then release → `out1=out0=busy=done=0` and they stay 0 for 100 cycles.
- **Label with parity 1:** `vel=3`, `sr_adr=8'hA5`, `sr_dat=0`, pulse `st` → w=32'hA5000001. Pulse train is 1,0,1,0,0,1,0,1, then 23×`0`, then `1`. Each pulse is 25 cycles wide followed by 25 null cycles. `busy` is high for 1800 cycles, followed by a single `done` pulse.
- **Data bit mapping:** `sr_adr=0`, `sr_dat=23'h000001` → w=32'h00800000 (parity 0). The only `out1` pulse is the 9th bit, starting at cycle 8·50 after accept.
- **Rate and gap at `vel=0`:** `sr_adr=8'h01`, `sr_dat=23'h7FFFFF` → pulse width is 2000 cycles and the post-word gap is 16000 cycles. `vel` toggled mid-word has no effect.
- **Start handling and loopback:** `st` during busy is ignored. `st` held high gives back-to-back words with exactly a 200-cycle null gap. With `out1`/`out0` looped into `AR_RXD_2`, the receiver reproduces `sr_adr`/`sr_dat` and pulses `ce_wr`.
- **Reset mid-word:** assert `rst_n=0` during bit 10 → both outputs drop within the same cycle with no clock edge. After release, a new `st` sends a complete, correct word.

Source files
------------

// File: rtl/arinc429_txd.sv
// ARINC 429 word transmitter: label + 23-bit data + odd parity, sent MSB-first
// as bipolar return-to-zero pulses on out1/out0 at one of four bit rates.
module arinc429_txd #(
  parameter int Fclk     = 50000000,
  parameter int V1Mb     = 1000000,
  parameter int V100kb   = 100000,
  parameter int V50kb    = 50000,
  parameter int V12_5kb  = 12500,
  parameter int GAP_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st,
  input  logic [1:0]  vel,
  input  logic [7:0]  sr_adr,
  input  logic [22:0] sr_dat,
  output logic        out1,
  output logic        out0,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_NULL, S_GAP} state_t;

  localparam logic [10:0] NT0 = 11'(Fclk / (2 * V12_5kb));
  localparam logic [10:0] NT1 = 11'(Fclk / (2 * V50kb));
  localparam logic [10:0] NT2 = 11'(Fclk / (2 * V100kb));
  localparam logic [10:0] NT3 = 11'(Fclk / (2 * V1Mb));
  // The gap is counted in half-bits so the 11-bit counter covers any rate.
  localparam int          GW    = (GAP_BITS > 0) ? $clog2(2 * GAP_BITS + 1) : 1;
  localparam logic [GW-1:0] GLAST = GW'(2 * GAP_BITS - 1);

  state_t        state, state_n;
  logic [31:0]   w, w_n, wa;
  logic [30:0]   body;
  logic [10:0]   nt, nt_n, nt_sel, cnt, cnt_n;
  logic [4:0]    idx, idx_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic          out1_n, out0_n, busy_n, done_n, half_end;

  always_comb begin
    body[30:23] = sr_adr;
    for (int i = 0; i < 23; i++) body[22-i] = sr_dat[i];
    wa = {body, ~^body};
  end

  always_comb begin
    case (vel)
      2'd0:    nt_sel = NT0;
      2'd1:    nt_sel = NT1;
      2'd2:    nt_sel = NT2;
      default: nt_sel = NT3;
    endcase
  end

  assign half_end = (cnt == nt - 11'd1);

  always_comb begin
    state_n = state;
    w_n     = w;
    nt_n    = nt;
    cnt_n   = cnt;
    idx_n   = idx;
    gcnt_n  = gcnt;
    out1_n  = 1'b0;
    out0_n  = 1'b0;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (st) begin
          w_n     = wa;
          nt_n    = nt_sel;
          cnt_n   = '0;
          idx_n   = 5'd31;
          out1_n  = wa[31];
          out0_n  = ~wa[31];
          busy_n  = 1'b1;
          state_n = S_PULSE;
        end
      end
      S_PULSE: begin
        if (half_end) begin
          cnt_n   = '0;
          state_n = S_NULL;
        end else begin
          cnt_n  = cnt + 11'd1;
          out1_n = w[idx];
          out0_n = ~w[idx];
        end
      end
      S_NULL: begin
        if (!half_end) begin
          cnt_n = cnt + 11'd1;
        end else begin
          cnt_n = '0;
          if (idx != 5'd0) begin
            idx_n   = idx - 5'd1;
            out1_n  = w[idx - 5'd1];
            out0_n  = ~w[idx - 5'd1];
            state_n = S_PULSE;
          end else if (GAP_BITS == 0) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            gcnt_n  = '0;
            state_n = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (!half_end) begin
          cnt_n = cnt + 11'd1;
        end else begin
          cnt_n = '0;
          if (gcnt == GLAST) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            gcnt_n = gcnt + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Async reset nulls the line at once and abandons any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      w     <= '0;
      nt    <= '0;
      cnt   <= '0;
      idx   <= '0;
      gcnt  <= '0;
      out1  <= 1'b0;
      out0  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      w     <= w_n;
      nt    <= nt_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      gcnt  <= gcnt_n;
      out1  <= out1_n;
      out0  <= out0_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule
